// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine payment controller.
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2,
        REFUND   = 2'd3
    } vend_state_e;

    localparam int unsigned COIN_HALF_VAL = 1;
    localparam int unsigned COIN_ONE_VAL  = 2;

endpackage : vend_pkg

// File: rtl/vend_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module vend_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;

    // done is registered alongside the count so it lines up with cnt_q == 0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            done  <= 1'b1;
        end else if (load) begin
            cnt_q <= value;
            done  <= (value == '0);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
            done  <= (cnt_q == W'(1));
        end
    end

endmodule : vend_timer

// File: rtl/vend_ctrl.sv
// Vending-machine payment controller: accumulates coins, drives a fixed-length
// dispense enable, and returns change or a full refund.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned PRICE       = 5,
    parameter int unsigned CREDIT_W    = 4,
    parameter int unsigned DISP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_half,
    input  logic                coin_one,
    input  logic                cancel,
    output logic                drink_en,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int unsigned TIMER_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    if (((1 << CREDIT_W) - 1) < (PRICE + 2)) begin : g_bad_credit_w
        $error("vend_ctrl: CREDIT_W too narrow for PRICE+2");
    end
    if (DISP_CYCLES < 1) begin : g_bad_disp_cycles
        $error("vend_ctrl: DISP_CYCLES must be >= 1");
    end

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic [CREDIT_W-1:0] change_amt_d;
    logic [CREDIT_W-1:0] sum;
    logic                drink_en_d;
    logic                change_valid_d;
    logic                busy_d;
    logic                tmr_load;
    logic                tmr_done;

    vend_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (TIMER_W'(DISP_CYCLES - 1)),
        .done  (tmr_done)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            credit       <= '0;
            drink_en     <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit       <= credit_d;
            drink_en     <= drink_en_d;
            change_valid <= change_valid_d;
            change_amt   <= change_amt_d;
            busy         <= busy_d;
        end
    end

    // Next state and next output values; outputs reflect the state being entered
    always_comb begin
        state_d        = state_q;
        credit_d       = credit;
        drink_en_d     = 1'b0;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        busy_d         = 1'b0;
        tmr_load       = 1'b0;
        sum            = credit
                       + (coin_half ? CREDIT_W'(COIN_HALF_VAL) : '0)
                       + (coin_one  ? CREDIT_W'(COIN_ONE_VAL)  : '0);

        unique case (state_q)
            COLLECT: begin
                if (cancel && (sum != '0)) begin
                    state_d        = REFUND;
                    credit_d       = '0;
                    change_valid_d = 1'b1;
                    change_amt_d   = sum;
                end else if (sum >= CREDIT_W'(PRICE)) begin
                    state_d    = DISPENSE;
                    credit_d   = sum;
                    tmr_load   = 1'b1;
                    drink_en_d = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    credit_d = sum;
                end
            end
            DISPENSE: begin
                busy_d = 1'b1;
                if (tmr_done) begin
                    state_d  = CHANGE;
                    credit_d = '0;
                    if (credit > CREDIT_W'(PRICE)) begin
                        change_valid_d = 1'b1;
                        change_amt_d   = credit - CREDIT_W'(PRICE);
                    end
                end else begin
                    drink_en_d = 1'b1;
                end
            end
            CHANGE: begin
                state_d = COLLECT;
            end
            REFUND: begin
                state_d = COLLECT;
            end
            default: begin
                state_d  = COLLECT;
                credit_d = '0;
            end
        endcase
    end

endmodule : vend_ctrl
